// File: rtl/video_mode_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// video_mode_sequencer_pkg
// Shared definitions for the pixel-clock video start-up sequencer: the state
// encoding that is also shown on the debug LEDs, and a width helper for the
// parameterised counters.
// -----------------------------------------------------------------------------
package video_mode_sequencer_pkg;

    localparam int STATE_W = 3;

    // Encodings 5..7 are never entered; the FSM returns them to ST_WAIT_LOCK.
    typedef enum logic [STATE_W-1:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_SYNC      = 3'd2,
        ST_RUN       = 3'd3,
        ST_BLANK     = 3'd4
    } seq_state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/video_mode_sequencer_btn_debounce.sv
// -----------------------------------------------------------------------------
// video_mode_sequencer_btn_debounce
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle pulse on each debounced press.
// Ports:
//   clk      in  1  pixel clock
//   rst_n    in  1  active-low reset, already synchronised to clk
//   btn_raw  in  1  raw asynchronous button, active high
//   press    out 1  one-cycle pulse on the rising edge of the debounced value
// -----------------------------------------------------------------------------
module video_mode_sequencer_btn_debounce #(
    parameter int C_debounce_bits = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    logic                       btn_meta;
    logic                       btn_s;
    logic                       stable;
    logic [C_debounce_bits-1:0] cnt;

    // The counter only runs while the synced input disagrees with the stable
    // value; the stable value follows after 2**C_debounce_bits disagreeing
    // samples in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
            stable   <= 1'b0;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            btn_meta <= btn_raw;
            btn_s    <= btn_meta;
            press    <= 1'b0;
            if (btn_s == stable) begin
                cnt <= '0;
            end else if (&cnt) begin
                stable <= btn_s;
                cnt    <= '0;
                press  <= btn_s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/video_mode_sequencer.sv
// -----------------------------------------------------------------------------
// video_mode_sequencer
// Start-up and run-time sequencer for the pixel-clock video path. Holds the
// timing generator in reset until the PLL has been locked for a settle period,
// un-blanks at a frame boundary, and steps the test pattern on a debounced
// button press at vsync with forced blank frames after each switch.
// Ports:
//   clk_pixel    in   1   pixel clock, the only clock
//   rst_n        in   1   asynchronous active-low reset
//   clk_locked   in   1   PLL lock (asynchronous)
//   btn_next     in   1   raw push button (asynchronous, active high)
//   vga_vsync    in   1   vsync pulse from the timing generator
//   vga_enable   out  1   run enable for the timing generator
//   blank_force  out  1   forces blanking into vga2dvid
//   pattern_sel  out  PW  test pattern index
//   seq_state    out  3   current state encoding for LED debug
// -----------------------------------------------------------------------------
module video_mode_sequencer
    import video_mode_sequencer_pkg::*;
#(
    parameter int C_settle_cycles = 1024,
    parameter int C_debounce_bits = 16,
    parameter int C_patterns      = 4,
    parameter int C_blank_frames  = 1,
    localparam int PW             = $clog2(C_patterns)
) (
    input  logic               clk_pixel,
    input  logic               rst_n,
    input  logic               clk_locked,
    input  logic               btn_next,
    input  logic               vga_vsync,
    output logic               vga_enable,
    output logic               blank_force,
    output logic [PW-1:0]      pattern_sel,
    output logic [STATE_W-1:0] seq_state
);

    localparam int SW = cnt_width(C_settle_cycles);
    localparam int FW = cnt_width(C_blank_frames + 1);
    // SETTLE leaves on the edge where the counter would reach C_settle_cycles-1.
    localparam logic [SW-1:0] SETTLE_LAST = SW'((C_settle_cycles >= 2) ? C_settle_cycles - 2 : 0);
    localparam logic [FW-1:0] BLANK_LAST  = FW'(C_blank_frames - 1);
    localparam logic [PW-1:0] PAT_LAST    = PW'(C_patterns - 1);

    logic [1:0]    rst_sync;
    logic          rst_n_sync;
    logic          lock_meta;
    logic          lock_s;
    logic          vsync_q;
    logic          vsync_rise;
    logic          press;
    logic          pending;
    logic          take_switch;
    logic [SW-1:0] settle_cnt;
    logic [FW-1:0] frame_cnt;
    seq_state_t    state;

    // Reset asserts immediately and releases two clean edges later.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_sync = rst_sync[1];

    always_ff @(posedge clk_pixel or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            vsync_q   <= 1'b0;
        end else begin
            lock_meta <= clk_locked;
            lock_s    <= lock_meta;
            vsync_q   <= vga_vsync;
        end
    end

    video_mode_sequencer_btn_debounce #(
        .C_debounce_bits(C_debounce_bits)
    ) u_btn_debounce (
        .clk    (clk_pixel),
        .rst_n  (rst_n_sync),
        .btn_raw(btn_next),
        .press  (press)
    );

    // vsync from a generator held in reset carries no frame information.
    assign vsync_rise  = vga_vsync & ~vsync_q & vga_enable;
    assign take_switch = (state == ST_RUN) && lock_s && vsync_rise && pending;
    assign seq_state   = state;

    always_ff @(posedge clk_pixel or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state       <= ST_WAIT_LOCK;
            vga_enable  <= 1'b0;
            blank_force <= 1'b1;
            pattern_sel <= '0;
            pending     <= 1'b0;
            settle_cnt  <= '0;
            frame_cnt   <= '0;
        end else begin
            case (state)
                ST_WAIT_LOCK: begin
                    vga_enable  <= 1'b0;
                    blank_force <= 1'b1;
                    settle_cnt  <= '0;
                    if (lock_s) begin
                        if (C_settle_cycles == 1) begin
                            state      <= ST_SYNC;
                            vga_enable <= 1'b1;
                        end else begin
                            state <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (!lock_s) begin
                        state <= ST_WAIT_LOCK;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= settle_cnt + 1'b1;
                        state      <= ST_SYNC;
                        vga_enable <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_SYNC, ST_RUN, ST_BLANK: begin
                    if (!lock_s) begin
                        state       <= ST_WAIT_LOCK;
                        vga_enable  <= 1'b0;
                        blank_force <= 1'b1;
                    end else if (state == ST_SYNC) begin
                        if (vsync_rise) begin
                            state       <= ST_RUN;
                            blank_force <= 1'b0;
                        end
                    end else if (state == ST_RUN) begin
                        if (take_switch) begin
                            pattern_sel <= (pattern_sel == PAT_LAST) ? '0 : pattern_sel + 1'b1;
                            blank_force <= 1'b1;
                            frame_cnt   <= '0;
                            state       <= ST_BLANK;
                        end
                    end else if (vsync_rise) begin
                        frame_cnt <= frame_cnt + 1'b1;
                        if (frame_cnt == BLANK_LAST) begin
                            state       <= ST_RUN;
                            blank_force <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= ST_WAIT_LOCK;
                    vga_enable  <= 1'b0;
                    blank_force <= 1'b1;
                end
            endcase

            // A press arriving with the switching vsync is absorbed by the
            // switch; otherwise presses coalesce into the single pending bit.
            if (take_switch)  pending <= 1'b0;
            else if (press)   pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_video_mode_sequencer.sv
module tb_video_mode_sequencer;

    localparam int PW      = 2;
    localparam int S_WAIT  = 0;
    localparam int S_SYNC  = 2;
    localparam int S_RUN   = 3;
    localparam int S_BLANK = 4;

    logic          clk_pixel = 1'b0;
    logic          rst_n;
    logic          clk_locked;
    logic          btn_next;
    logic          vga_vsync;
    logic          vga_enable;
    logic          blank_force;
    logic [PW-1:0] pattern_sel;
    logic [2:0]    seq_state;

    int checks = 0;
    int errors = 0;
    int cur_pat = 0;
    bit mon_en = 1'b0;
    logic [PW-1:0] prev_pat = '0;
    logic [PW-1:0] exp_q[$];

    typedef struct {
        int press_len;
        int press_count;
        bit exp_switch;
        int exp_pattern;
    } vec_t;

    vec_t vecs[8];

    video_mode_sequencer #(
        .C_settle_cycles(8),
        .C_debounce_bits(3),
        .C_patterns     (3),
        .C_blank_frames (2)
    ) dut (
        .clk_pixel  (clk_pixel),
        .rst_n      (rst_n),
        .clk_locked (clk_locked),
        .btn_next   (btn_next),
        .vga_vsync  (vga_vsync),
        .vga_enable (vga_enable),
        .blank_force(blank_force),
        .pattern_sel(pattern_sel),
        .seq_state  (seq_state)
    );

    // clock / watchdog
    always #5 clk_pixel = ~clk_pixel;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // scoreboard: every pattern_sel change must match the next queued value
    always @(posedge clk_pixel) begin
        #1;
        if (mon_en && pattern_sel !== prev_pat) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_switch: got %0d expected no change from %0d", pattern_sel, prev_pat);
            end else begin
                check("pattern_switch", int'(pattern_sel), int'(exp_q.pop_front()));
            end
        end
        prev_pat = pattern_sel;
    end

    // driver tasks
    task automatic step();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic vsync_rise_step();
        vga_vsync = 1'b1;
        step();
    endtask

    task automatic vsync_tail(input int n);
        step();
        vga_vsync = 1'b0;
        repeat (n) step();
    endtask

    task automatic press_btn(input int len);
        btn_next = 1'b1;
        repeat (len) step();
        btn_next = 1'b0;
        repeat (14) step();
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        repeat (4) step();
        for (int p = 0; p < v.press_count; p++) press_btn(v.press_len);
        check($sformatf("vec%0d_midframe_hold", idx), int'(pattern_sel), cur_pat);
        if (v.exp_switch) exp_q.push_back(PW'(v.exp_pattern));
        vsync_rise_step();
        check($sformatf("vec%0d_state", idx), int'(seq_state), v.exp_switch ? S_BLANK : S_RUN);
        check($sformatf("vec%0d_blank", idx), int'(blank_force), int'(v.exp_switch));
        vsync_tail(20);
        if (v.exp_switch) begin
            vsync_rise_step();
            check($sformatf("vec%0d_blank_frame2", idx), int'(blank_force), 1);
            vsync_tail(20);
            vsync_rise_step();
            check($sformatf("vec%0d_back_to_run", idx), int'(seq_state), S_RUN);
            check($sformatf("vec%0d_unblank", idx), int'(blank_force), 0);
            vsync_tail(20);
        end
        check($sformatf("vec%0d_pattern", idx), int'(pattern_sel), v.exp_pattern);
        cur_pat = v.exp_pattern;
    endtask

    initial begin
        int n;
        vecs[0] = '{20, 1, 1'b1, 1};
        vecs[1] = '{20, 1, 1'b1, 2};
        vecs[2] = '{20, 1, 1'b1, 0};
        vecs[3] = '{5,  1, 1'b0, 0};
        vecs[4] = '{5,  2, 1'b0, 0};
        vecs[5] = '{20, 2, 1'b1, 1};
        vecs[6] = '{0,  0, 1'b0, 1};
        vecs[7] = '{20, 1, 1'b1, 2};

        // reset
        rst_n      = 1'b0;
        clk_locked = 1'b0;
        btn_next   = 1'b0;
        vga_vsync  = 1'b0;
        repeat (3) step();
        check("reset_enable", int'(vga_enable), 0);
        check("reset_blank", int'(blank_force), 1);
        check("reset_pattern", int'(pattern_sel), 0);
        check("reset_state", int'(seq_state), S_WAIT);
        rst_n = 1'b1;
        repeat (4) step();
        mon_en = 1'b1;

        // start-up: enable 2+8 cycles after lock, un-blank after first vsync
        clk_locked = 1'b1;
        n = 0;
        while (!vga_enable && n < 40) begin
            step();
            n++;
        end
        check("startup_settle_cycles", n, 10);
        check("startup_state_sync", int'(seq_state), S_SYNC);
        repeat (5) step();
        check("sync_still_blank", int'(blank_force), 1);
        vsync_rise_step();
        check("first_vsync_run", int'(seq_state), S_RUN);
        check("first_vsync_unblank", int'(blank_force), 0);
        vsync_tail(20);

        // table-driven press/switch frames
        for (int i = 0; i < 8; i++) apply_vec(vecs[i], i);

        // loss of lock in RUN for one cycle
        clk_locked = 1'b0;
        step();
        clk_locked = 1'b1;
        n = 1;
        while (int'(seq_state) != S_WAIT && n < 3) begin
            step();
            n++;
        end
        check("lockloss_state", int'(seq_state), S_WAIT);
        check("lockloss_enable", int'(vga_enable), 0);
        check("lockloss_blank", int'(blank_force), 1);
        check("lockloss_pattern_held", int'(pattern_sel), cur_pat);
        n = 0;
        while (!vga_enable && n < 40) begin
            step();
            n++;
        end
        check("relock_settle_cycles", n, 8);
        repeat (3) step();
        vsync_rise_step();
        check("relock_run", int'(seq_state), S_RUN);
        vsync_tail(20);
        check("relock_pattern", int'(pattern_sel), cur_pat);

        // press debounced on the same edge as vsync_rise: switch one frame later
        btn_next = 1'b1;
        repeat (10) step();
        vga_vsync = 1'b1;
        step();
        check("simul_state", int'(seq_state), S_RUN);
        check("simul_pattern", int'(pattern_sel), cur_pat);
        step();
        vga_vsync = 1'b0;
        repeat (8) step();
        btn_next = 1'b0;
        repeat (14) step();
        exp_q.push_back(PW'(0));
        vsync_rise_step();
        check("simul_late_switch_state", int'(seq_state), S_BLANK);
        check("simul_late_switch_pattern", int'(pattern_sel), 0);
        cur_pat = 0;
        vsync_tail(4);

        // press during BLANK: no switch in BLANK, switch on first RUN vsync
        press_btn(20);
        check("blank_press_hold", int'(pattern_sel), 0);
        vsync_rise_step();
        check("blank_press_still_blank", int'(seq_state), S_BLANK);
        vsync_tail(20);
        vsync_rise_step();
        check("blank_press_run", int'(seq_state), S_RUN);
        check("blank_press_run_pattern", int'(pattern_sel), 0);
        vsync_tail(20);
        exp_q.push_back(PW'(1));
        vsync_rise_step();
        check("blank_press_switch", int'(pattern_sel), 1);
        check("blank_press_switch_state", int'(seq_state), S_BLANK);
        vsync_tail(5);

        // asynchronous reset mid-BLANK, away from any clock edge
        check("pre_reset_enable", int'(vga_enable), 1);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_enable", int'(vga_enable), 0);
        check("async_reset_blank", int'(blank_force), 1);
        check("async_reset_pattern", int'(pattern_sel), 0);
        check("async_reset_state", int'(seq_state), S_WAIT);

        check("scoreboard_drained", exp_q.size(), 0);

        // report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
